// File: rtl/io_frame_pkg.sv
// Shared definitions for the UART frame sequencer: FSM encoding and byte constants.
package io_frame_pkg;

  typedef enum logic [1:0] {
    RECV        = 2'd0,
    COMPUTE_IN  = 2'd1,
    COMPUTE_OUT = 2'd2,
    SEND        = 2'd3
  } frame_state_t;

  localparam int BYTE_BITS = 8;
  localparam logic [BYTE_BITS-1:0] DROP_COUNT_MAX = 8'd255;

endpackage

// File: rtl/io_frame_watchdog.sv
// Idle-clock watchdog: counts enabled clocks with no activity and pulses expire
// on the clock where the count would reach TimeoutClocks-1.
module io_frame_watchdog #(
  parameter int TimeoutClocks = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(TimeoutClocks);

  logic [CNT_W-1:0] idle_cnt;

  // Activity (clear) in the expiry cycle suppresses the timeout.
  assign expire = enable && !clear && (idle_cnt == CNT_W'(TimeoutClocks - 2));

  // Idle counter: restarts on activity, when disabled, or after firing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (clear || !enable || expire) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/io_frame_sequencer.sv
// Frame sequencer between the UART and a ready/valid computation: assembles
// input bytes big-endian, hands the frame over, collects the result and
// serializes it MSB byte first, throttling the host through clear_to_send_out_n.
module io_frame_sequencer
  import io_frame_pkg::*;
#(
  parameter int InputBytes    = 1,
  parameter int OutputBytes   = 1,
  parameter int TimeoutClocks = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [BYTE_BITS-1:0]          rx_byte,
  input  logic                          rx_byte_valid,
  output logic                          clear_to_send_out_n,
  output logic [BYTE_BITS*InputBytes-1:0]  flat_input,
  output logic                          flat_input_valid,
  input  logic                          flat_input_ready,
  input  logic [BYTE_BITS*OutputBytes-1:0] flat_output,
  input  logic                          flat_output_valid,
  output logic                          flat_output_ready,
  output logic [BYTE_BITS-1:0]          tx_byte,
  output logic                          tx_byte_valid,
  input  logic                          tx_byte_ready,
  output logic                          frame_error,
  output logic [BYTE_BITS-1:0]          dropped_count
);

  localparam int IN_W      = BYTE_BITS * InputBytes;
  localparam int OUT_W     = BYTE_BITS * OutputBytes;
  localparam int IN_CNT_W  = (InputBytes  > 1) ? $clog2(InputBytes)  : 1;
  localparam int OUT_CNT_W = (OutputBytes > 1) ? $clog2(OutputBytes) : 1;

  frame_state_t         state;
  frame_state_t         state_next;
  logic [IN_CNT_W-1:0]  in_cnt;
  logic [OUT_CNT_W-1:0] out_cnt;
  logic [OUT_W-1:0]     out_shift;
  logic                 in_last;
  logic                 out_last;
  logic                 wd_enable;
  logic                 wd_expire;

  assign tx_byte   = out_shift[OUT_W-1 -: BYTE_BITS];
  assign in_last   = (in_cnt == IN_CNT_W'(InputBytes - 1));
  assign out_last  = (out_cnt == OUT_CNT_W'(OutputBytes - 1));
  assign wd_enable = (state == RECV) && (in_cnt != '0);

  io_frame_watchdog #(
    .TimeoutClocks(TimeoutClocks)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (rx_byte_valid),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  // Next-state decode; also feeds the registered clear-to-send output.
  always_comb begin
    state_next = state;
    case (state)
      RECV:        if (rx_byte_valid && in_last)      state_next = COMPUTE_IN;
      COMPUTE_IN:  if (flat_input_ready)              state_next = COMPUTE_OUT;
      COMPUTE_OUT: if (flat_output_valid)             state_next = SEND;
      SEND:        if (tx_byte_ready && out_last)     state_next = RECV;
      default:                                        state_next = RECV;
    endcase
  end

  // Sequencer FSM with registered handshake outputs and shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= RECV;
      clear_to_send_out_n <= 1'b1;
      flat_input          <= '0;
      flat_input_valid    <= 1'b0;
      flat_output_ready   <= 1'b0;
      out_shift           <= '0;
      tx_byte_valid       <= 1'b0;
      frame_error         <= 1'b0;
      dropped_count       <= '0;
      in_cnt              <= '0;
      out_cnt             <= '0;
    end else begin
      state               <= state_next;
      clear_to_send_out_n <= (state_next != RECV);
      frame_error         <= 1'b0;

      if (rx_byte_valid && (state != RECV) && (dropped_count != DROP_COUNT_MAX)) begin
        dropped_count <= dropped_count + 8'd1;
      end

      case (state)
        RECV: begin
          if (rx_byte_valid) begin
            flat_input <= (flat_input << BYTE_BITS) | IN_W'(rx_byte);
            if (in_last) begin
              in_cnt           <= '0;
              flat_input_valid <= 1'b1;
            end else begin
              in_cnt <= in_cnt + IN_CNT_W'(1);
            end
          end else if (wd_expire) begin
            in_cnt      <= '0;
            frame_error <= 1'b1;
          end
        end
        COMPUTE_IN: begin
          if (flat_input_ready) begin
            flat_input_valid  <= 1'b0;
            flat_output_ready <= 1'b1;
          end
        end
        COMPUTE_OUT: begin
          if (flat_output_valid) begin
            out_shift         <= flat_output;
            flat_output_ready <= 1'b0;
            tx_byte_valid     <= 1'b1;
            out_cnt           <= '0;
          end
        end
        SEND: begin
          if (tx_byte_ready) begin
            out_shift <= out_shift << BYTE_BITS;
            if (out_last) begin
              tx_byte_valid <= 1'b0;
              out_cnt       <= '0;
            end else begin
              out_cnt <= out_cnt + OUT_CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_io_frame_sequencer.sv
// Directed bench: instance A (1-byte frames) and instance B (2-byte frames,
// 16-clock timeout) exercised with hand-computed expectations.
module tb_io_frame_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: InputBytes=1, OutputBytes=1
  logic [7:0]  a_rx_byte, a_tx_byte, a_drop, a_fi, a_fo;
  logic        a_rx_valid, a_cts_n, a_fi_valid, a_fi_ready, a_fo_valid, a_fo_ready;
  logic        a_tx_valid, a_tx_ready, a_ferr;

  // Instance B: InputBytes=2, OutputBytes=2, TimeoutClocks=16
  logic [7:0]  b_rx_byte, b_tx_byte, b_drop;
  logic [15:0] b_fi, b_fo;
  logic        b_rx_valid, b_cts_n, b_fi_valid, b_fi_ready, b_fo_valid, b_fo_ready;
  logic        b_tx_valid, b_tx_ready, b_ferr;

  io_frame_sequencer #(
    .InputBytes(1), .OutputBytes(1), .TimeoutClocks(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .rx_byte(a_rx_byte), .rx_byte_valid(a_rx_valid),
    .clear_to_send_out_n(a_cts_n),
    .flat_input(a_fi), .flat_input_valid(a_fi_valid), .flat_input_ready(a_fi_ready),
    .flat_output(a_fo), .flat_output_valid(a_fo_valid), .flat_output_ready(a_fo_ready),
    .tx_byte(a_tx_byte), .tx_byte_valid(a_tx_valid), .tx_byte_ready(a_tx_ready),
    .frame_error(a_ferr), .dropped_count(a_drop)
  );

  io_frame_sequencer #(
    .InputBytes(2), .OutputBytes(2), .TimeoutClocks(16)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .rx_byte(b_rx_byte), .rx_byte_valid(b_rx_valid),
    .clear_to_send_out_n(b_cts_n),
    .flat_input(b_fi), .flat_input_valid(b_fi_valid), .flat_input_ready(b_fi_ready),
    .flat_output(b_fo), .flat_output_valid(b_fo_valid), .flat_output_ready(b_fo_ready),
    .tx_byte(b_tx_byte), .tx_byte_valid(b_tx_valid), .tx_byte_ready(b_tx_ready),
    .frame_error(b_ferr), .dropped_count(b_drop)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs set after this are sampled at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full 0x55 -> 0x56 round trip on instance A with cycle-exact checks.
  task automatic a_round_trip(input string tag);
    a_rx_byte = 8'h55; a_rx_valid = 1'b1; tick(); a_rx_valid = 1'b0;
    check({tag, "_fi"},       a_fi, 32'h55);
    check({tag, "_fi_valid"}, a_fi_valid, 1);
    check({tag, "_cts_hi1"},  a_cts_n, 1);
    a_fi_ready = 1'b1; tick(); a_fi_ready = 1'b0;
    check({tag, "_fi_valid_fall"}, a_fi_valid, 0);
    check({tag, "_fo_ready"},      a_fo_ready, 1);
    check({tag, "_cts_hi2"},       a_cts_n, 1);
    a_fo = 8'h56; a_fo_valid = 1'b1; tick(); a_fo_valid = 1'b0;
    check({tag, "_tx_valid"},     a_tx_valid, 1);
    check({tag, "_tx_byte"},      a_tx_byte, 32'h56);
    check({tag, "_fo_ready_fall"}, a_fo_ready, 0);
    check({tag, "_cts_hi3"},      a_cts_n, 1);
    a_tx_ready = 1'b1; tick(); a_tx_ready = 1'b0;
    check({tag, "_tx_valid_fall"}, a_tx_valid, 0);
    check({tag, "_cts_lo"},        a_cts_n, 0);
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0;
    a_rx_byte = '0; a_rx_valid = 0; a_fi_ready = 0; a_fo = '0; a_fo_valid = 0; a_tx_ready = 0;
    b_rx_byte = '0; b_rx_valid = 0; b_fi_ready = 0; b_fo = '0; b_fo_valid = 0; b_tx_ready = 0;
    tick(); tick();

    // Reset values
    check("rst_cts_n",    a_cts_n, 1);
    check("rst_fi_valid", a_fi_valid, 0);
    check("rst_fo_ready", a_fo_ready, 0);
    check("rst_tx_valid", a_tx_valid, 0);
    check("rst_ferr",     a_ferr, 0);
    check("rst_fi",       a_fi, 0);
    check("rst_tx_byte",  a_tx_byte, 0);
    check("rst_drop",     a_drop, 0);
    check("rst_b_cts_n",  b_cts_n, 1);

    rst_n = 1'b1; tick();
    check("cts_fall_after_rst",   a_cts_n, 0);
    check("b_cts_fall_after_rst", b_cts_n, 0);

    a_round_trip("rt1");

    // Drops during COMPUTE_OUT saturate and leave the FSM alone
    a_rx_byte = 8'h10; a_rx_valid = 1'b1; tick(); a_rx_valid = 1'b0;
    a_fi_ready = 1'b1; tick(); a_fi_ready = 1'b0;
    a_rx_byte = 8'hEE; a_rx_valid = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    a_rx_valid = 1'b0;
    check("drop_sat",       a_drop, 255);
    check("drop_fo_ready",  a_fo_ready, 1);
    check("drop_fi_held",   a_fi, 32'h10);
    check("drop_fi_valid",  a_fi_valid, 0);
    check("drop_cts_n",     a_cts_n, 1);
    a_fo = 8'h11; a_fo_valid = 1'b1; tick(); a_fo_valid = 1'b0;
    check("drop_tx_byte",   a_tx_byte, 32'h11);
    check("drop_tx_valid",  a_tx_valid, 1);
    tick(); tick();
    check("send_hold_tx_byte", a_tx_byte, 32'h11);

    // Asynchronous reset mid-SEND
    rst_n = 1'b0; #1;
    check("async_tx_valid", a_tx_valid, 0);
    check("async_tx_byte",  a_tx_byte, 0);
    check("async_cts_n",    a_cts_n, 1);
    check("async_drop",     a_drop, 0);
    check("async_fi",       a_fi, 0);
    check("async_fo_ready", a_fo_ready, 0);
    tick();
    rst_n = 1'b1; tick();
    check("cts_fall_after_rst2", a_cts_n, 0);
    a_round_trip("rt2");

    // Instance B: big-endian assembly and stalled two-byte send
    b_rx_byte = 8'h12; b_rx_valid = 1'b1; tick(); b_rx_valid = 1'b0;
    check("b_partial_fi",       b_fi, 32'h0012);
    check("b_partial_fi_valid", b_fi_valid, 0);
    check("b_partial_cts_n",    b_cts_n, 0);
    b_rx_byte = 8'h34; b_rx_valid = 1'b1; tick(); b_rx_valid = 1'b0;
    check("b_fi_1234",  b_fi, 32'h1234);
    check("b_fi_valid", b_fi_valid, 1);
    b_fi_ready = 1'b1; tick(); b_fi_ready = 1'b0;
    b_fo = 16'hABCD; b_fo_valid = 1'b1; tick(); b_fo_valid = 1'b0;
    check("b_tx_valid", b_tx_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check("b_stall_AB", b_tx_byte, 32'hAB);
      tick();
    end
    b_tx_ready = 1'b1; tick(); b_tx_ready = 1'b0;
    check("b_tx_valid_mid", b_tx_valid, 1);
    check("b_cts_mid",      b_cts_n, 1);
    for (int i = 0; i < 5; i++) begin
      check("b_stall_CD", b_tx_byte, 32'hCD);
      tick();
    end
    b_tx_ready = 1'b1; tick(); b_tx_ready = 1'b0;
    check("b_tx_valid_end", b_tx_valid, 0);
    check("b_cts_end",      b_cts_n, 0);

    // Timeout: one byte, 15 idle clocks, single frame_error pulse
    b_rx_byte = 8'h77; b_rx_valid = 1'b1; tick(); b_rx_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      if (b_ferr) pulses++;
      tick();
    end
    if (b_ferr) pulses++;
    check("to_no_early_pulse", pulses, 0);
    tick();
    check("to_ferr_pulse", b_ferr, 1);
    tick();
    check("to_ferr_one_clock", b_ferr, 0);
    b_rx_byte = 8'h01; b_rx_valid = 1'b1; tick(); b_rx_valid = 1'b0;
    check("to_count_cleared", b_fi_valid, 0);
    b_rx_byte = 8'h02; b_rx_valid = 1'b1; tick(); b_rx_valid = 1'b0;
    check("to_fi_0102",  b_fi, 32'h0102);
    check("to_fi_valid", b_fi_valid, 1);
    b_fi_ready = 1'b1; tick(); b_fi_ready = 1'b0;
    b_fo = 16'h0203; b_fo_valid = 1'b1; tick(); b_fo_valid = 1'b0;
    check("b2b_byte0", b_tx_byte, 32'h02);
    b_tx_ready = 1'b1; tick();
    check("b2b_byte1", b_tx_byte, 32'h03);
    check("b2b_valid", b_tx_valid, 1);
    tick(); b_tx_ready = 1'b0;
    check("b2b_done", b_tx_valid, 0);

    // Byte on the exact expiry clock wins over the timeout
    b_rx_byte = 8'hA1; b_rx_valid = 1'b1; tick(); b_rx_valid = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    b_rx_byte = 8'hA2; b_rx_valid = 1'b1; tick(); b_rx_valid = 1'b0;
    check("exp_no_ferr",  b_ferr, 0);
    check("exp_fi_valid", b_fi_valid, 1);
    check("exp_fi",       b_fi, 32'hA1A2);
    check("b_no_drops",   b_drop, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_frame_sequencer.md
# io_frame_sequencer

Controller that sequences a fixed-latency-agnostic ready/valid computation behind the ice40 UART. It assembles bytes from the UART receiver into a flat input word and presents it to the computation. It then accepts the flat result and serializes it byte-by-byte to the UART transmitter. It throttles the host via `clear_to_send_out_n` and discards stale partial frames on timeout.

## Interface
Parameters:
- `InputBytes`, 1, bytes per input frame (>=1)
- `OutputBytes`, 1, bytes per result (>=1)
- `TimeoutClocks`, 1024, idle clocks after which a partial input frame is discarded (>=2)

Ports:
- `clk`  in  1  sole clock
- `rst_n`  in  1  asynchronous, active-low reset
- `rx_byte`  in  8  received byte
- `rx_byte_valid`  in  1  one-cycle strobe; no backpressure
- `clear_to_send_out_n`  out  1  0 = host may send
- `flat_input`  out  8*InputBytes  assembled frame
- `flat_input_valid`  out  1  frame offered to computation
- `flat_input_ready`  in  1  computation accepts frame
- `flat_output`  in  8*OutputBytes  result word
- `flat_output_valid`  in  1  result offered
- `flat_output_ready`  out  1  sequencer accepts result
- `tx_byte`  out  8  byte to transmitter
- `tx_byte_valid`  out  1  byte offered
- `tx_byte_ready`  in  1  transmitter accepts byte
- `frame_error`  out  1  one-cycle pulse on timeout discard
- `dropped_count`  out  8  bytes dropped outside RECV, saturates at 255

## Operation
- States: RECV → COMPUTE_IN → COMPUTE_OUT → SEND → RECV.
- RECV: each `rx_byte_valid` shifts `rx_byte` into `flat_input` from the LSB end. The first byte ends in bits [8*InputBytes-1 -: 8], so the frame is big-endian. The byte count increments. On the InputBytes-th byte, go to COMPUTE_IN.
- COMPUTE_IN: `flat_input_valid`=1 and `flat_input` is stable. On `flat_input_ready`, go to COMPUTE_OUT.
- COMPUTE_OUT: `flat_output_ready`=1. On `flat_output_valid`, capture `flat_output` into the shift register and go to SEND.
- SEND: `tx_byte` is the most significant unsent byte and `tx_byte_valid`=1. On each `tx_byte_ready` handshake, advance to the next byte. After the OutputBytes-th handshake, go to RECV with the byte count cleared.
- `clear_to_send_out_n` is registered: 0 iff next state is RECV.
- Timeout: in RECV with byte count >0, the idle counter increments each clock without `rx_byte_valid`. When it reaches TimeoutClocks-1, clear the count and pulse `frame_error`. `rx_byte_valid` in the same cycle wins: the byte is accepted and no timeout fires. With count 0 the counter holds at 0.
- `rx_byte_valid` outside RECV: the byte is discarded and `dropped_count` increments, saturating at 255.
- Reset, async and possibly mid-frame or mid-SEND: state RECV, counts 0, `clear_to_send_out_n`=1, `flat_input_valid`=`flat_output_ready`=`tx_byte_valid`=`frame_error`=0, `flat_input`=`tx_byte`=0, `dropped_count`=0. `clear_to_send_out_n` falls on the first clock edge after deassertion.

## Timing
- Last input byte strobed at cycle t: `flat_input_valid` and `clear_to_send_out_n` rise at t+1.
- `flat_input_ready` sampled high at cycle u: `flat_input_valid` falls and `flat_output_ready` rises at u+1. A combinational ready/valid loop is never created; all outputs are registered.
- `flat_output_valid` handshake at v: `tx_byte_valid` rises at v+1 with the first byte.
- `tx_byte` changes only on the clock after a handshake. Back-to-back handshakes give one byte per clock.
- Final tx handshake at w: `tx_byte_valid` falls and `clear_to_send_out_n` falls at w+1. A byte strobed at w+1 is accepted.
- A timeout pulse is exactly one clock, coincident with the count clear.

## Structure
- Package `io_frame_pkg`: state encoding (RECV=0, COMPUTE_IN=1, COMPUTE_OUT=2, SEND=3), `BYTE_BITS`=8, `DROP_COUNT_MAX`=255.
- Sub-module `io_frame_watchdog` holds the idle counter and timeout comparator. It is parameterized by TimeoutClocks, takes clear/enable inputs, and outputs an expire pulse. The sequencer FSM and shift registers live in the top module.

## Test plan
- InputBytes=OutputBytes=1, model returns input+1. Receive 0x55, then `flat_input`=0x55, `tx_byte`=0x56. `clear_to_send_out_n` is 1 from the cycle after the rx strobe until the cycle after the tx handshake, then 0.
- InputBytes=2. Receive 0x12 then 0x34, giving `flat_input`=0x1234. OutputBytes=2 result 0xABCD is sent as 0xAB then 0xCD, with `tx_byte_ready` stalled 5 clocks per byte and `tx_byte` stable throughout.
- TimeoutClocks=16, InputBytes=2. One byte, then 15 idle clocks, gives a single `frame_error` pulse. Next frame 0x01,0x02 gives `flat_input`=0x0102.
- Strobe `rx_byte_valid` on the exact expiry clock: no `frame_error`, and the frame completes.
- Inject 300 rx strobes during COMPUTE_OUT: `dropped_count`=255, and the FSM is unaffected.
- Assert `rst_n` mid-SEND: outputs take reset values immediately. After release, a full 0x55→0x56 round trip succeeds.
